// File: rtl/hazard_pkg.sv
// Shared constants for the hazard/forwarding controller: forwarding-mux
// encodings and default widths.
package hazard_pkg;

  localparam int REG_ADDR_W_DEF = 5;
  localparam int CNT_W_DEF      = 32;

  // 2'b11 is deliberately unused; the ALU operand mux treats it as illegal.
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

endpackage

// File: rtl/fwd_select.sv
// Forwarding-source select for one ALU operand. The youngest in-flight
// writer (EX/MEM) wins over MEM/WB; x0 is never forwarded.
module fwd_select
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic [REG_ADDR_W-1:0] i_rs,
  input  logic [REG_ADDR_W-1:0] i_mem_rd,
  input  logic                  i_mem_reg_write,
  input  logic [REG_ADDR_W-1:0] i_wb_rd,
  input  logic                  i_wb_reg_write,
  output fwd_sel_e              o_sel
);

  logic w_mem_hit;
  logic w_wb_hit;

  assign w_mem_hit = i_mem_reg_write && (i_mem_rd != '0) && (i_mem_rd == i_rs);
  assign w_wb_hit  = i_wb_reg_write  && (i_wb_rd  != '0) && (i_wb_rd  == i_rs);

  always_comb begin
    o_sel = FWD_RF;
    if (w_mem_hit) begin
      o_sel = FWD_MEM;
    end else if (w_wb_hit) begin
      o_sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Hazard and forwarding controller for the 5-stage core: shadow metadata
// pipeline, operand-forwarding selects, load-use stall, branch squash, counters.
module hazard_forward_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_id_valid,
  input  logic [REG_ADDR_W-1:0] i_id_rs1,
  input  logic [REG_ADDR_W-1:0] i_id_rs2,
  input  logic                  i_id_rs1_used,
  input  logic                  i_id_rs2_used,
  input  logic [REG_ADDR_W-1:0] i_id_rd,
  input  logic                  i_id_reg_write,
  input  logic                  i_id_mem_read,
  input  logic                  i_ex_branch_taken,
  output logic [1:0]            o_forward_a,
  output logic [1:0]            o_forward_b,
  output logic                  o_pc_write_en,
  output logic                  o_ifid_write_en,
  output logic                  o_ifid_flush,
  output logic                  o_idex_bubble,
  output logic [CNT_W-1:0]      o_stall_count,
  output logic [CNT_W-1:0]      o_flush_count
);

  logic [REG_ADDR_W-1:0] r_ex_rs1;
  logic [REG_ADDR_W-1:0] r_ex_rs2;
  logic [REG_ADDR_W-1:0] r_ex_rd;
  logic                  r_ex_reg_write;
  logic                  r_ex_mem_read;

  logic [REG_ADDR_W-1:0] r_mem_rd;
  logic                  r_mem_reg_write;
  logic                  r_mem_mem_read;

  logic [REG_ADDR_W-1:0] r_wb_rd;
  logic                  r_wb_reg_write;

  logic [CNT_W-1:0]      r_stall_count;
  logic [CNT_W-1:0]      r_flush_count;

  logic                  w_load_use;
  logic                  w_flush;
  logic                  w_bubble;
  logic                  w_load_ex;
  fwd_sel_e              w_fwd_a;
  fwd_sel_e              w_fwd_b;

  fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
    .i_rs            (r_ex_rs1),
    .i_mem_rd        (r_mem_rd),
    .i_mem_reg_write (r_mem_reg_write),
    .i_wb_rd         (r_wb_rd),
    .i_wb_reg_write  (r_wb_reg_write),
    .o_sel           (w_fwd_a)
  );

  fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
    .i_rs            (r_ex_rs2),
    .i_mem_rd        (r_mem_rd),
    .i_mem_reg_write (r_mem_reg_write),
    .i_wb_rd         (r_wb_rd),
    .i_wb_reg_write  (r_wb_reg_write),
    .o_sel           (w_fwd_b)
  );

  assign o_forward_a = w_fwd_a;
  assign o_forward_b = w_fwd_b;

  assign w_load_use = i_id_valid && r_ex_mem_read && (r_ex_rd != '0) &&
                      ((i_id_rs1_used && (r_ex_rd == i_id_rs1)) ||
                       (i_id_rs2_used && (r_ex_rd == i_id_rs2)));
  assign w_flush    = i_ex_branch_taken;
  assign w_bubble   = w_flush || w_load_use;
  assign w_load_ex  = i_id_valid && !w_bubble;

  // A redirect overrides a stall: the front end must advance to load the target.
  assign o_pc_write_en   = w_flush || !w_load_use;
  assign o_ifid_write_en = w_flush || !w_load_use;
  assign o_ifid_flush    = w_flush;
  assign o_idex_bubble   = w_bubble;
  assign o_stall_count   = r_stall_count;
  assign o_flush_count   = r_flush_count;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_ex_rs1        <= '0;
      r_ex_rs2        <= '0;
      r_ex_rd         <= '0;
      r_ex_reg_write  <= 1'b0;
      r_ex_mem_read   <= 1'b0;
      r_mem_rd        <= '0;
      r_mem_reg_write <= 1'b0;
      r_mem_mem_read  <= 1'b0;
      r_wb_rd         <= '0;
      r_wb_reg_write  <= 1'b0;
    end else begin
      r_wb_rd         <= r_mem_rd;
      r_wb_reg_write  <= r_mem_reg_write;
      r_mem_rd        <= r_ex_rd;
      r_mem_reg_write <= r_ex_reg_write;
      r_mem_mem_read  <= r_ex_mem_read;
      if (w_load_ex) begin
        r_ex_rs1       <= i_id_rs1;
        r_ex_rs2       <= i_id_rs2;
        r_ex_rd        <= i_id_rd;
        r_ex_reg_write <= i_id_reg_write;
        r_ex_mem_read  <= i_id_mem_read;
      end else begin
        r_ex_rs1       <= '0;
        r_ex_rs2       <= '0;
        r_ex_rd        <= '0;
        r_ex_reg_write <= 1'b0;
        r_ex_mem_read  <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_stall_count <= '0;
      r_flush_count <= '0;
    end else begin
      if (w_load_use && !w_flush && (r_stall_count != '1)) begin
        r_stall_count <= r_stall_count + CNT_W'(1);
      end
      if (w_flush && (r_flush_count != '1)) begin
        r_flush_count <= r_flush_count + CNT_W'(1);
      end
    end
  end

  // Every load writes a register; a load in MEM without reg_write means corrupt metadata.
  a_mem_load_writes : assert property (
    @(posedge i_clk) disable iff (!i_reset_n) r_mem_mem_read |-> r_mem_reg_write
  );

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed bench for hazard_forward_ctrl: forwarding, load-use stall, flush
// priority, x0 handling, mid-stream reset and counter saturation.
module tb_hazard_forward_ctrl;

  localparam int RW = 5;
  localparam int CW = 32;

  logic          i_clk;
  logic          i_reset_n;
  logic          i_id_valid;
  logic [RW-1:0] i_id_rs1;
  logic [RW-1:0] i_id_rs2;
  logic          i_id_rs1_used;
  logic          i_id_rs2_used;
  logic [RW-1:0] i_id_rd;
  logic          i_id_reg_write;
  logic          i_id_mem_read;
  logic          i_ex_branch_taken;
  logic [1:0]    o_forward_a;
  logic [1:0]    o_forward_b;
  logic          o_pc_write_en;
  logic          o_ifid_write_en;
  logic          o_ifid_flush;
  logic          o_idex_bubble;
  logic [CW-1:0] o_stall_count;
  logic [CW-1:0] o_flush_count;

  int n_checks = 0;
  int n_pass   = 0;
  logic [CW-1:0] exp_stall;
  logic [CW-1:0] exp_flush;
  logic [CW-1:0] all_ones;

  hazard_forward_ctrl #(.REG_ADDR_W(RW), .CNT_W(CW)) dut (
    .i_clk             (i_clk),
    .i_reset_n         (i_reset_n),
    .i_id_valid        (i_id_valid),
    .i_id_rs1          (i_id_rs1),
    .i_id_rs2          (i_id_rs2),
    .i_id_rs1_used     (i_id_rs1_used),
    .i_id_rs2_used     (i_id_rs2_used),
    .i_id_rd           (i_id_rd),
    .i_id_reg_write    (i_id_reg_write),
    .i_id_mem_read     (i_id_mem_read),
    .i_ex_branch_taken (i_ex_branch_taken),
    .o_forward_a       (o_forward_a),
    .o_forward_b       (o_forward_b),
    .o_pc_write_en     (o_pc_write_en),
    .o_ifid_write_en   (o_ifid_write_en),
    .o_ifid_flush      (o_ifid_flush),
    .o_idex_bubble     (o_idex_bubble),
    .o_stall_count     (o_stall_count),
    .o_flush_count     (o_flush_count)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic drv(input logic v, input logic [RW-1:0] rs1, input logic [RW-1:0] rs2,
                     input logic u1, input logic u2, input logic [RW-1:0] rd,
                     input logic rw, input logic mr, input logic br);
    i_id_valid        = v;
    i_id_rs1          = rs1;
    i_id_rs2          = rs2;
    i_id_rs1_used     = u1;
    i_id_rs2_used     = u2;
    i_id_rd           = rd;
    i_id_reg_write    = rw;
    i_id_mem_read     = mr;
    i_ex_branch_taken = br;
  endtask

  task automatic nop();
    drv(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drain();
    nop();
    repeat (3) cyc();
  endtask

  task automatic test_reset();
    nop();
    i_reset_n = 1'b0;
    #12;
    n_checks++; if (o_forward_a !== 2'b00) $display("FAIL reset_fwd_a got %b want 00", o_forward_a); else n_pass++;
    n_checks++; if (o_forward_b !== 2'b00) $display("FAIL reset_fwd_b got %b want 00", o_forward_b); else n_pass++;
    @(negedge i_clk);
    i_reset_n = 1'b1;
    cyc();
    @(negedge i_clk);
    n_checks++; if (o_pc_write_en !== 1'b1 || o_ifid_write_en !== 1'b1) $display("FAIL reset_we got pc=%b ifid=%b want 1/1", o_pc_write_en, o_ifid_write_en); else n_pass++;
    n_checks++; if (o_ifid_flush !== 1'b0 || o_idex_bubble !== 1'b0) $display("FAIL reset_flush got flush=%b bubble=%b want 0/0", o_ifid_flush, o_idex_bubble); else n_pass++;
    n_checks++; if (o_stall_count !== '0 || o_flush_count !== '0) $display("FAIL reset_counts got %0d/%0d want 0/0", o_stall_count, o_flush_count); else n_pass++;
    cyc();
    exp_stall = '0;
    exp_flush = '0;
  endtask

  task automatic test_load_use();
    drv(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);   // lw x5,0(x1)
    cyc();
    drv(1'b1, 5'd5, 5'd2, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);   // add x6,x5,x2
    @(negedge i_clk);
    n_checks++; if (o_pc_write_en !== 1'b0 || o_ifid_write_en !== 1'b0) $display("FAIL lu_stall_we got pc=%b ifid=%b want 0/0", o_pc_write_en, o_ifid_write_en); else n_pass++;
    n_checks++; if (o_idex_bubble !== 1'b1 || o_ifid_flush !== 1'b0) $display("FAIL lu_stall_bubble got bubble=%b flush=%b want 1/0", o_idex_bubble, o_ifid_flush); else n_pass++;
    cyc();
    exp_stall = exp_stall + 1;
    @(negedge i_clk);
    n_checks++; if (o_pc_write_en !== 1'b1 || o_idex_bubble !== 1'b0) $display("FAIL lu_release got pc=%b bubble=%b want 1/0", o_pc_write_en, o_idex_bubble); else n_pass++;
    n_checks++; if (o_stall_count !== exp_stall) $display("FAIL lu_stall_count got %0d want %0d", o_stall_count, exp_stall); else n_pass++;
    cyc();
    nop();
    @(negedge i_clk);
    n_checks++; if (o_forward_a !== 2'b01 || o_forward_b !== 2'b00) $display("FAIL lu_forward got a=%b b=%b want 01/00", o_forward_a, o_forward_b); else n_pass++;
    n_checks++; if (o_stall_count !== exp_stall) $display("FAIL lu_one_cycle got %0d want %0d", o_stall_count, exp_stall); else n_pass++;
    drain();
    // Matching rs2 that the instruction does not read must not stall.
    drv(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
    cyc();
    drv(1'b1, 5'd1, 5'd5, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
    @(negedge i_clk);
    n_checks++; if (o_pc_write_en !== 1'b1 || o_idex_bubble !== 1'b0) $display("FAIL lu_unused_rs2 got pc=%b bubble=%b want 1/0", o_pc_write_en, o_idex_bubble); else n_pass++;
    cyc();
    drain();
  endtask

  task automatic test_fwd_mem();
    drv(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);   // add x5,x1,x2
    cyc();
    drv(1'b1, 5'd5, 5'd3, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);   // sub x6,x5,x3
    cyc();
    nop();
    @(negedge i_clk);
    n_checks++; if (o_forward_a !== 2'b10 || o_forward_b !== 2'b00) $display("FAIL fwd_mem got a=%b b=%b want 10/00", o_forward_a, o_forward_b); else n_pass++;
    drain();
  endtask

  task automatic test_fwd_wb();
    drv(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);   // add x5
    cyc();
    nop();
    cyc();
    drv(1'b1, 5'd4, 5'd5, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);   // or x7,x4,x5
    cyc();
    nop();
    @(negedge i_clk);
    n_checks++; if (o_forward_b !== 2'b01 || o_forward_a !== 2'b00) $display("FAIL fwd_wb got a=%b b=%b want 00/01", o_forward_a, o_forward_b); else n_pass++;
    drain();
    drv(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);   // add x5,x1,x2
    cyc();
    drv(1'b1, 5'd1, 5'd1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);   // add x5,x1,x1
    cyc();
    drv(1'b1, 5'd4, 5'd5, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);   // or x7,x4,x5
    cyc();
    nop();
    @(negedge i_clk);
    n_checks++; if (o_forward_b !== 2'b10 || o_forward_a !== 2'b00) $display("FAIL fwd_priority got a=%b b=%b want 00/10", o_forward_a, o_forward_b); else n_pass++;
    drain();
  endtask

  task automatic test_x0();
    drv(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);   // addi x0,x1,1
    cyc();
    drv(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);   // add x6,x0,x0
    cyc();
    nop();
    @(negedge i_clk);
    n_checks++; if (o_forward_a !== 2'b00 || o_forward_b !== 2'b00) $display("FAIL x0_fwd got a=%b b=%b want 00/00", o_forward_a, o_forward_b); else n_pass++;
    drain();
    drv(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);   // lw x0,0(x1)
    cyc();
    drv(1'b1, 5'd0, 5'd2, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
    @(negedge i_clk);
    n_checks++; if (o_pc_write_en !== 1'b1 || o_ifid_write_en !== 1'b1 || o_idex_bubble !== 1'b0) $display("FAIL x0_no_stall got pc=%b ifid=%b bubble=%b want 1/1/0", o_pc_write_en, o_ifid_write_en, o_idex_bubble); else n_pass++;
    cyc();
    drain();
    n_checks++; if (o_stall_count !== exp_stall) $display("FAIL x0_stall_count got %0d want %0d", o_stall_count, exp_stall); else n_pass++;
  endtask

  task automatic test_flush_vs_stall();
    drv(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);   // lw x5
    cyc();
    drv(1'b1, 5'd5, 5'd2, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b1);   // dependent add + taken branch
    @(negedge i_clk);
    n_checks++; if (o_ifid_flush !== 1'b1 || o_idex_bubble !== 1'b1) $display("FAIL fvs_flush got flush=%b bubble=%b want 1/1", o_ifid_flush, o_idex_bubble); else n_pass++;
    n_checks++; if (o_pc_write_en !== 1'b1 || o_ifid_write_en !== 1'b1) $display("FAIL fvs_we got pc=%b ifid=%b want 1/1", o_pc_write_en, o_ifid_write_en); else n_pass++;
    cyc();
    exp_flush = exp_flush + 1;
    nop();
    @(negedge i_clk);
    n_checks++; if (o_flush_count !== exp_flush) $display("FAIL fvs_flush_count got %0d want %0d", o_flush_count, exp_flush); else n_pass++;
    n_checks++; if (o_stall_count !== exp_stall) $display("FAIL fvs_stall_count got %0d want %0d", o_stall_count, exp_stall); else n_pass++;
    drain();
  endtask

  task automatic test_back_to_back();
    drv(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    cyc();
    cyc();
    exp_flush = exp_flush + 2;
    nop();
    @(negedge i_clk);
    n_checks++; if (o_flush_count !== exp_flush) $display("FAIL b2b_flush_count got %0d want %0d", o_flush_count, exp_flush); else n_pass++;
    drain();
  endtask

  task automatic test_reset_mid();
    drv(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);   // add x5
    cyc();
    drv(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);   // reader of x5
    cyc();
    nop();
    @(negedge i_clk);
    n_checks++; if (o_forward_a !== 2'b10) $display("FAIL rmid_pre got %b want 10", o_forward_a); else n_pass++;
    #1;
    i_reset_n = 1'b0;
    #1;
    n_checks++; if (o_forward_a !== 2'b00 || o_forward_b !== 2'b00) $display("FAIL rmid_fwd got a=%b b=%b want 00/00", o_forward_a, o_forward_b); else n_pass++;
    n_checks++; if (o_stall_count !== '0 || o_flush_count !== '0) $display("FAIL rmid_counts got %0d/%0d want 0/0", o_stall_count, o_flush_count); else n_pass++;
    @(negedge i_clk);
    i_reset_n = 1'b1;
    cyc();
    @(negedge i_clk);
    n_checks++; if (o_forward_a !== 2'b00 || o_forward_b !== 2'b00) $display("FAIL rmid_post got a=%b b=%b want 00/00", o_forward_a, o_forward_b); else n_pass++;
    cyc();
    exp_stall = '0;
    exp_flush = '0;
  endtask

  task automatic test_saturate();
    force dut.r_stall_count = all_ones;
    #1;
    release dut.r_stall_count;
    n_checks++; if (o_stall_count !== all_ones) $display("FAIL sat_preload got %h want %h", o_stall_count, all_ones); else n_pass++;
    cyc();
    drv(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);   // lw x5
    cyc();
    drv(1'b1, 5'd5, 5'd2, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
    @(negedge i_clk);
    n_checks++; if (o_idex_bubble !== 1'b1) $display("FAIL sat_stall got bubble=%b want 1", o_idex_bubble); else n_pass++;
    cyc();
    nop();
    @(negedge i_clk);
    n_checks++; if (o_stall_count !== all_ones) $display("FAIL sat_hold got %h want %h", o_stall_count, all_ones); else n_pass++;
    n_checks++; if (o_flush_count !== exp_flush) $display("FAIL sat_flush got %0d want %0d", o_flush_count, exp_flush); else n_pass++;
    drain();
  endtask

  initial begin
    all_ones  = '1;
    exp_stall = '0;
    exp_flush = '0;
    i_reset_n = 1'b0;
    nop();
    test_reset();
    test_load_use();
    test_fwd_mem();
    test_fwd_wb();
    test_x0();
    test_flush_vs_stall();
    test_back_to_back();
    test_reset_mid();
    test_saturate();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hazard_forward_ctrl.md
# hazard_forward_ctrl

Pipeline hazard and forwarding controller for the 5-stage RISC-V core. It keeps its own shadow copies of the ID/EX, EX/MEM and MEM/WB register-address and control metadata. From these it drives the two 3-to-1 ALU-operand forwarding muxes, stalls the front end on load-use hazards and squashes wrong-path instructions on taken branches. It sits beside the pipeline registers and is the only source of the forwarding-mux selects and the PC/IF-ID write enables.

## Interface
- REG_ADDR_W, 5, architectural register index width
- CNT_W, 32, width of performance counters
- clk  in  1  core clock, all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- id_valid  in  1  decode stage holds a real instruction
- id_rs1, id_rs2  in  REG_ADDR_W  decode-stage source registers
- id_rs1_used, id_rs2_used  in  1  source actually read by the instruction
- id_rd  in  REG_ADDR_W  decode-stage destination
- id_reg_write, id_mem_read  in  1  decode-stage control bits
- ex_branch_taken  in  1  branch/jump in EX resolved taken (redirect this cycle)
- forward_a, forward_b  out  2  ALU operand mux selects: 00 register file, 01 MEM/WB, 10 EX/MEM; 11 never driven
- pc_write_en, ifid_write_en  out  1  front-end advance enables
- ifid_flush, idex_bubble  out  1  zero the IF/ID register / load a bubble into ID/EX
- stall_count, flush_count  out  CNT_W  saturating event counters

## Operation
- Shadow pipeline: three metadata stages. EX shadow holds rs1, rs2, rd, reg_write, mem_read. MEM shadow holds rd, reg_write, mem_read. WB shadow holds rd, reg_write. Every cycle: WB<=MEM, MEM<=EX, EX<=decode fields, or a bubble (all control bits 0, addresses 0) when idex_bubble=1 or id_valid=0.
- Forwarding, per operand X in {rs1→forward_a, rs2→forward_b}, computed from the EX shadow:
  - 10 if MEM.reg_write, MEM.rd≠0 and MEM.rd==EX.rsX.
  - else 01 if WB.reg_write, WB.rd≠0 and WB.rd==EX.rsX.
  - else 00. EX/MEM has priority over MEM/WB.
- Load-use stall: load_use = id_valid & EX.mem_read & EX.rd≠0 & ((id_rs1_used & EX.rd==id_rs1) | (id_rs2_used & EX.rd==id_rs2)).
- Flush: ex_branch_taken gives ifid_flush=1 and idex_bubble=1.
- Priority: flush over stall. With both active, pc_write_en=1 (the redirect must load) and ifid_write_en=1. A stall alone gives pc_write_en=0, ifid_write_en=0, idex_bubble=1.
- Register-file write-to-decode bypass is done in the register file (write-first), not here.
- Counters: stall_count +1 per cycle with load_use & ~ex_branch_taken. flush_count +1 per cycle with ex_branch_taken. Both saturate at all-ones.

## Timing
- Reset (async assert, sync-released use on the next rising edge): all shadow stages are bubbles and counters are 0. Outputs therefore read forward_a=forward_b=00, pc_write_en=ifid_write_en=1, ifid_flush=idex_bubble=0.
- Forward selects are combinational from registered shadow state and are valid during the same cycle the instruction is in EX (0-cycle latency).
- Stall/flush outputs are combinational from current inputs plus the EX shadow, and take effect at the next rising edge.
- A load-use stall lasts exactly one cycle. The next cycle the load is in the MEM shadow, the EX shadow holds a bubble, load_use deasserts and the consumer later forwards via 01.
- Reset mid-operation: all in-flight shadow state is discarded immediately and no forwarding is asserted in the first post-reset cycle.

## Structure
- Shared package hazard_pkg: FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10, and the REG_ADDR_W default.
- Sub-module fwd_select (pure combinational, one per operand, instantiated twice). Inputs: rs, mem_rd, mem_reg_write, wb_rd, wb_reg_write. Output: 2-bit select.
- Shadow registers, stall/flush logic and counters live in the top module.

## Test plan
- add x5,x1,x2 then sub x6,x5,x3 → forward_a=10 in sub's EX cycle, forward_b=00.
- add x5; nop; or x7,x4,x5 → forward_b=01 in or's EX cycle. With an intervening add x5 both one and two back → 10 (EX/MEM priority).
- lw x5,0(x1) then add x6,x5,x2 → exactly one cycle with pc_write_en=0, ifid_write_en=0, idex_bubble=1, stall_count=1; add then forwards with forward_a=01.
- Writer to x0 (addi x0,x1,1) followed by a reader of x0 → forward_a=00. lw x0 then a reader of x0 → no stall.
- ex_branch_taken=1 in the same cycle as a load-use condition → ifid_flush=1, idex_bubble=1, pc_write_en=1, flush_count +1, stall_count unchanged.
- reset_n pulsed low mid-stream with a pending MEM-stage writer → selects 00 and counters 0 immediately. Preload stall_count to all-ones by force → a further stall keeps it all-ones.
